// File: rtl/risc_v_mike_uart_rx.sv
// risc_v_mike_uart_rx: 8N1 UART receive front end with valid/ready output,
// framing-error pulse and sticky overrun flag.
module risc_v_mike_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    input  logic                 i_clr_err,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2 - 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               r_state, w_state_next;
    logic                 r_sync1, r_sync2;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [IDX_W-1:0]     r_idx, w_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data, w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_overrun, w_overrun_next;
    logic                 r_frame_err, w_frame_err_next;
    logic                 w_rx_sync;
    logic                 w_bit_end;

    assign w_rx_sync = r_sync2;
    assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Two-flop synchroniser on the asynchronous rx pin; resets to the idle level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_overrun   <= w_overrun_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // Next-state, bit sampling and handshake logic.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = r_valid;
        w_overrun_next   = r_overrun;
        w_frame_err_next = 1'b0;

        // Consumer accept; a byte loaded this same cycle overrides below.
        if (r_valid && i_rx_ready) begin
            w_valid_next = 1'b0;
        end
        // A drop in the same cycle overrides the clear below.
        if (i_clr_err) begin
            w_overrun_next = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                if (!w_rx_sync) begin
                    w_state_next = StStart;
                    w_cnt_next   = '0;
                end
            end
            StStart: begin
                if (r_cnt == CNT_W'(HALF)) begin
                    w_cnt_next = '0;
                    if (!w_rx_sync) begin
                        w_state_next = StData;
                        w_idx_next   = '0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as a glitch.
                        w_state_next = StIdle;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = w_rx_sync;
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_next = StStop;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (w_rx_sync) begin
                        w_state_next = StIdle;
                        if (!r_valid || i_rx_ready) begin
                            w_data_next  = r_shift;
                            w_valid_next = 1'b1;
                        end else begin
                            w_overrun_next = 1'b1;
                        end
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = StBreak;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (w_rx_sync) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_rx_data   = r_data;
    assign o_rx_valid  = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_risc_v_mike_uart_rx.sv
// tb_risc_v_mike_uart_rx: directed bench for the UART receiver (CLKS_PER_BIT=16, 8N1).
module tb_risc_v_mike_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Monitor state (written only by the monitor blocks).
    int unsigned cyc      = 0;
    logic [7:0]  got_q[$];
    int unsigned fe_cyc   = 0;
    int unsigned v_hi     = 0;
    int unsigned t_valid  = 0;
    logic        prev_valid = 1'b0;

    int unsigned t_fall;
    int unsigned base_got;
    int unsigned base_fe;
    int unsigned base_vhi;
    logic [9:0]  fr;

    risc_v_mike_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (rx_ready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .i_clr_err   (clr_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs mid-cycle: record handshakes, valid/frame_err widths and first-valid time.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cyc <= fe_cyc + 1;
        if (rx_valid) v_hi <= v_hi + 1;
        if (rx_valid && !prev_valid) t_valid <= cyc;
        prev_valid <= rx_valid;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: bench still running at 1 ms, required to finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, and a stop bit at the given level (left on the line).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            tick(CPB);
        end
    endtask

    function automatic logic [31:0] got_at(input int unsigned i);
        if (i < got_q.size()) return {24'h0, got_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; clr_err = 1'b0;
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(5);

        // Frame 0xA5, consumer always ready.
        base_got = got_q.size(); base_fe = fe_cyc; base_vhi = v_hi;
        t_fall = cyc;
        send_frame(8'hA5, 1'b1);
        tick(4);
        check("a5_count", got_q.size() - base_got, 1);
        check("a5_byte", got_at(base_got), 8'hA5);
        // First edge after the drive captures the fall; valid follows the 154th edge after that one.
        check("a5_latency", t_valid - t_fall, 155);
        check("a5_valid_width", v_hi - base_vhi, 1);
        check("a5_frame_err", fe_cyc - base_fe, 0);
        check("a5_overrun", overrun, 0);

        // Four-cycle low glitch: aborted at the mid-start sample.
        base_got = got_q.size(); base_fe = fe_cyc;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(1);
        check("glitch_busy_mid", busy, 1);
        tick(7);
        check("glitch_busy_end", busy, 0);
        tick(20);
        check("glitch_no_byte", got_q.size() - base_got, 0);
        check("glitch_no_fe", fe_cyc - base_fe, 0);

        // Bad stop bit, line held low three more bit times, then a good frame.
        base_got = got_q.size(); base_fe = fe_cyc;
        send_frame(8'h3C, 1'b0);
        tick(3 * CPB);
        check("brk_fe_width", fe_cyc - base_fe, 1);
        check("brk_busy", busy, 1);
        check("brk_no_byte", got_q.size() - base_got, 0);
        rx = 1'b1;
        tick(4);
        check("brk_release", busy, 0);
        send_frame(8'h55, 1'b1);
        tick(4);
        check("brk_next_byte", got_at(base_got), 8'h55);
        check("brk_fe_total", fe_cyc - base_fe, 1);

        // Overrun: consumer stalled across two frames.
        base_got = got_q.size();
        rx_ready = 1'b0;
        send_frame(8'h12, 1'b1);
        tick(4);
        check("ovr_first_valid", rx_valid, 1);
        check("ovr_first_flag", overrun, 0);
        send_frame(8'h34, 1'b1);
        tick(4);
        check("ovr_held_data", rx_data, 8'h12);
        check("ovr_held_valid", rx_valid, 1);
        check("ovr_set", overrun, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("ovr_still_valid", rx_valid, 1);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_consumed", rx_valid, 0);
        check("ovr_consumed_byte", got_at(base_got), 8'h12);
        check("ovr_consumed_cnt", got_q.size() - base_got, 1);

        // Back-to-back frames with no idle gap.
        base_got = got_q.size(); base_fe = fe_cyc; base_vhi = v_hi;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        tick(4);
        check("b2b_count", got_q.size() - base_got, 3);
        check("b2b_byte0", got_at(base_got), 8'h00);
        check("b2b_byte1", got_at(base_got + 1), 8'hFF);
        check("b2b_byte2", got_at(base_got + 2), 8'h81);
        check("b2b_pulses", v_hi - base_vhi, 3);
        check("b2b_no_err", (fe_cyc - base_fe) + {31'h0, overrun}, 0);

        // Reset mid-DATA of 0x5A; the sender also abandons the frame.
        base_got = got_q.size();
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = fr[i];
            tick(CPB);
        end
        check("mid_busy", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_valid", rx_valid, 0);
        rst = 1'b0;
        tick(30);
        check("mid_no_byte", got_q.size() - base_got, 0);
        send_frame(8'hC3, 1'b1);
        tick(4);
        check("mid_next_byte", got_at(base_got), 8'hC3);
        check("mid_next_cnt", got_q.size() - base_got, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
